// File: rtl/apb_master_if.sv
// Command, response and APB4 bus signals of the APB requester.
// master: requester view; slave: sequencer plus completer view.
interface apb_master_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [DATA_W/8-1:0]   cmd_strb;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W/8-1:0]   pstrb;
    logic [DATA_W-1:0]     pwdata;
    logic                  pready;
    logic                  pslverr;
    logic [DATA_W-1:0]     prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  pready, pslverr, prdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pstrb, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output pready, pslverr, prdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pstrb, pwdata
    );
endinterface

// File: rtl/apb_master.sv
// APB4 requester: one command in flight, SETUP/ACCESS sequencing,
// one response pulse per command, optional wait-state timeout.
module apb_master #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset,
    apb_master_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e              state_q,       state_d;
    logic                psel_q,        psel_d;
    logic                penable_q,     penable_d;
    logic                pwrite_q,      pwrite_d;
    logic [ADDR_W-1:0]   paddr_q,       paddr_d;
    logic [STRB_W-1:0]   pstrb_q,       pstrb_d;
    logic [DATA_W-1:0]   pwdata_q,      pwdata_d;
    logic                rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q,   rsp_rdata_d;
    logic                rsp_err_q,     rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]    wait_cnt_q,    wait_cnt_d;

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pstrb_d       = pstrb_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_cnt_d    = wait_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    pwrite_d   = bus.cmd_write;
                    paddr_d    = bus.cmd_addr;
                    pwdata_d   = bus.cmd_wdata;
                    pstrb_d    = bus.cmd_write ? bus.cmd_strb : '0;
                    psel_d     = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = bus.pslverr;
                    rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
                    rsp_timeout_d = 1'b0;
                    state_d       = IDLE;
                end else if (TIMEOUT_CYCLES != 0 && wait_cnt_q == CNT_LAST) begin
                    // hung completer: abort and report as an error
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pstrb_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pstrb_q       <= pstrb_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign bus.cmd_ready   = (state_q == IDLE) & ~reset;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pstrb       = pstrb_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: vector table, random transfers
// against a transfer-level model, back-to-back and reset sequences.
module tb_apb_master;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    apb_master_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    apb_master #(
        .ADDR_W(12), .DATA_W(32), .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        bit          slverr;
        bit          early;
        logic [31:0] prdata;
        logic [31:0] e_rdata;
        bit          e_err;
        bit          e_to;
        int          e_psel;
        int          e_pen;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // transfer-level expectation from the wait-state count alone
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.e_to    = (v.waits >= TO);
        r.e_pen   = r.e_to ? TO : v.waits + 1;
        r.e_psel  = r.e_pen + 1;
        r.e_err   = r.e_to | v.slverr;
        r.e_rdata = (r.e_to || v.wr) ? 32'h0 : v.prdata;
        return r;
    endfunction

    task automatic xfer(input vec_t v);
        int npsel = 0;
        int npen = 0;
        int lat = -1;
        bit got = 0;
        bit bad = 0;
        logic [3:0] es;
        es = v.wr ? v.strb : 4'h0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.wr;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.cmd_strb  = v.strb;
        chk("cmd_ready_idle", {63'd0, bus.cmd_ready}, 64'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 12'($urandom);
        bus.cmd_wdata = $urandom;
        bus.cmd_write = ~v.wr;
        for (int c = 0; c < 64 && !got; c++) begin
            if (bus.rsp_valid) begin
                got = 1;
                lat = c;
            end else begin
                if (bus.psel) begin
                    npsel++;
                    if (bus.paddr !== v.addr || bus.pwrite !== v.wr ||
                        bus.pstrb !== es || bus.pwdata !== v.wdata)
                        bad = 1;
                end
                if (bus.penable) begin
                    bus.pready  = (npen >= v.waits);
                    bus.pslverr = bus.pready ? v.slverr : v.early;
                    bus.prdata  = bus.pready ? v.prdata : $urandom;
                    npen++;
                end else begin
                    bus.pready  = 1'b0;
                    bus.pslverr = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        chk("rsp_seen", {63'd0, got}, 64'd1);
        chk("rsp_rdata", bus.rsp_rdata, v.e_rdata);
        chk("rsp_err", {63'd0, bus.rsp_err}, {63'd0, v.e_err});
        chk("rsp_timeout", {63'd0, bus.rsp_timeout}, {63'd0, v.e_to});
        chk("psel_cycles", npsel, v.e_psel);
        chk("penable_cycles", npen, v.e_pen);
        chk("latency", lat, v.e_pen + 1);
        chk("bus_stable", {63'd0, bad}, 64'd0);
        chk("rsp_psel_low", {62'd0, bus.psel, bus.penable}, 64'd0);
        chk("rsp_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
        @(posedge clk); #1;
        chk("rsp_pulse", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rsp_hold", bus.rsp_rdata, v.e_rdata);
    endtask

    initial begin
        vec_t v;
        int nrsp;
        bit quiet;

        tbl[0] = '{1'b1, 12'h004, 32'hA5A51234, 4'hF, 0, 1'b0, 1'b0,
                   32'h0, 32'h0, 1'b0, 1'b0, 2, 1};
        tbl[1] = '{1'b0, 12'h008, 32'h11111111, 4'hF, 3, 1'b0, 1'b0,
                   32'h000000C3, 32'h000000C3, 1'b0, 1'b0, 5, 4};
        tbl[2] = '{1'b1, 12'hFFC, 32'h22222222, 4'h3, 0, 1'b1, 1'b0,
                   32'h0, 32'h0, 1'b1, 1'b0, 2, 1};
        tbl[3] = '{1'b1, 12'h010, 32'h33333333, 4'h1, 2, 1'b0, 1'b1,
                   32'h0, 32'h0, 1'b0, 1'b0, 4, 3};
        tbl[4] = '{1'b1, 12'h014, 32'h44444444, 4'h8, 2, 1'b1, 1'b1,
                   32'h0, 32'h0, 1'b1, 1'b0, 4, 3};
        tbl[5] = '{1'b0, 12'h020, 32'h0, 4'h0, 99, 1'b0, 1'b0,
                   32'hDEADBEEF, 32'h0, 1'b1, 1'b1, 17, 16};
        tbl[6] = '{1'b0, 12'h024, 32'h0, 4'h0, 0, 1'b0, 1'b0,
                   32'h12345678, 32'h12345678, 1'b0, 1'b0, 2, 1};
        tbl[7] = '{1'b0, 12'h030, 32'h0, 4'h0, 15, 1'b0, 1'b0,
                   32'h0000005A, 32'h0000005A, 1'b0, 1'b0, 17, 16};
        tbl[8] = '{1'b0, 12'h034, 32'h0, 4'h0, 16, 1'b0, 1'b0,
                   32'h0000005A, 32'h0, 1'b1, 1'b1, 17, 16};

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        bus.prdata    = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
        chk("reset_ctrl", {58'd0, bus.psel, bus.penable, bus.pwrite,
            bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 64'd0);
        chk("reset_data", {bus.paddr, bus.pstrb, bus.pwdata}, 64'd0);
        chk("reset_rdata", bus.rsp_rdata, 64'd0);
        reset = 1'b0;
        #1;
        chk("release_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);

        foreach (tbl[i]) xfer(tbl[i]);

        for (int i = 0; i < 30; i++) begin
            v.wr     = 1'($urandom);
            v.addr   = 12'($urandom);
            v.wdata  = $urandom;
            v.strb   = 4'($urandom);
            v.waits  = int'($urandom_range(0, 18));
            v.slverr = 1'($urandom);
            v.early  = 1'($urandom);
            v.prdata = $urandom;
            xfer(model(v));
        end

        // back-to-back with cmd_valid held high
        nrsp = 0;
        bus.pready    = 1'b1;
        bus.pslverr   = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) nrsp++;
            chk("b2b_rsp", {63'd0, bus.rsp_valid}, {63'd0, (e % 3) == 0});
            chk("b2b_psel", {63'd0, bus.psel}, {63'd0, (e % 3) != 0});
            if (e == 10) bus.cmd_valid = 1'b0;
        end
        chk("b2b_count", nrsp, 4);
        bus.pready = 1'b0;

        // reset during ACCESS discards the transfer
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 12'h040;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_access", {62'd0, bus.psel, bus.penable}, 64'd3);
        reset = 1'b1;
        bus.pready = 1'b1;
        #1;
        chk("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
        @(posedge clk); #1;
        chk("rst_bus_drop", {61'd0, bus.psel, bus.penable, bus.rsp_valid},
            64'd0);
        reset = 1'b0;
        bus.pready = 1'b0;
        #1;
        chk("rst_rel_ready", {63'd0, bus.cmd_ready}, 64'd1);
        quiet = 1;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.rsp_valid || bus.psel) quiet = 0;
        end
        chk("rst_no_rsp", {63'd0, quiet}, 64'd1);
        xfer(tbl[1]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB4 requester: converts a simple valid/ready command stream into APB SETUP/ACCESS transfers and returns one response per command.
- Drives the register-file-based UART slave (or any APB4 completer) from a test sequencer, a DMA engine or a CPU bridge.
- One outstanding transfer at a time. Optional wait-state timeout converts a hung completer into an error response.

Parameters:
- ADDR_W, 12, APB address width (paddr, cmd_addr).
- DATA_W, 32, APB data width; strobe width is DATA_W/8.
- TIMEOUT_CYCLES, 16, max ACCESS cycles with pready low before abort; 0 disables timeout.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  one-cycle pulse, response present.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  pslverr sampled at completion, or timeout.
- rsp_timeout  out  1  completion was a timeout abort.
- psel, penable, pwrite  out  1 each  APB control.
- paddr  out  ADDR_W  APB address.
- pstrb  out  DATA_W/8  APB strobes.
- pwdata  out  DATA_W  APB write data.
- pready, pslverr  in  1 each  completer handshake.
- prdata  in  DATA_W  completer read data.

Behaviour:
- Reset: clk and reset are the only clock/reset. reset is synchronous, active-high, and takes effect on the clk edge.
- Reset values: state=IDLE; psel, penable, pwrite, rsp_valid, rsp_err and rsp_timeout = 0; paddr, pstrb, pwdata and rsp_rdata = 0; wait counter = 0.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered except cmd_ready = (state==IDLE) & ~reset.
- IDLE: psel=0, penable=0.
  - On cmd_valid & cmd_ready: latch pwrite<=cmd_write, paddr<=cmd_addr, pwdata<=cmd_wdata.
  - Strobes: pstrb<=cmd_write ? cmd_strb : 0 (APB4: reads drive zero strobes).
  - Next state SETUP.
- SETUP, exactly 1 cycle: psel=1, penable=0; next state ACCESS.
- ACCESS: psel=1, penable=1. paddr, pwrite, pstrb and pwdata are held stable from SETUP until completion.
  - pready=1: completion. Next cycle IDLE with psel=penable=0, and:
    - rsp_valid=1;
    - rsp_err=pslverr;
    - rsp_rdata=(~pwrite) ? prdata : 0;
    - rsp_timeout=0.
  - pready=0: increment the wait counter.
    - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 on a pready-low cycle: abort. Next cycle IDLE with psel=penable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
    - The counter clears on entry to SETUP.
- pready and pslverr are sampled only when psel & penable. pslverr with pready=0 is ignored.
- rsp_valid is a single-cycle pulse with no backpressure. The consumer must accept it. rsp_rdata, rsp_err and rsp_timeout hold until the next response.
- Throughput: zero-wait-state transfers take 3 cycles each (accept, SETUP, ACCESS). In the response cycle cmd_ready=1, so back-to-back commands are accepted with no bubble.
- In IDLE, paddr, pwrite and pwdata keep their last values, so there is no bus toggling.
- Reset mid-transfer: psel and penable drop on that edge. No rsp_valid is produced for the aborted transfer, and the latched command is discarded.
- Command signals are ignored unless cmd_valid & cmd_ready.

Test Plan:
- Write, zero wait: cmd write addr=0x004, wdata=0xA5A5_1234, strb=0xF; slave pready=1 in ACCESS.
  - Required: psel high 2 cycles, penable high 1 cycle, pstrb=0xF.
  - Required: rsp_valid pulses 3 cycles after accept with rsp_err=0, rsp_rdata=0.
- Read, 3 wait states: cmd read addr=0x008; slave pready low 3 cycles, then high with prdata=0x0000_00C3.
  - Required: paddr stable for all 5 psel cycles, pstrb=0.
  - Required: rsp_rdata=0xC3, rsp_err=0.
- Slave error: write addr=0xFFC; slave pready=1, pslverr=1.
  - Required: rsp_err=1, rsp_timeout=0.
  - Then pslverr=1 with pready=0 for 2 cycles before pready: err is taken only at the completion cycle.
- Timeout (TIMEOUT_CYCLES=16): read with pready stuck 0.
  - Required: penable high exactly 16 cycles, then psel=penable=0.
  - Required: rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Next command still completes normally.
- Back-to-back plus reset: 4 zero-wait commands with cmd_valid held high → 4 responses at a 3-cycle cadence, no idle bubble.
  - Then assert reset during ACCESS of a 5th → psel=0 next edge, no rsp_valid, cmd_ready=1 after reset release.
